// File: rtl/eth_wb_pkg.sv
// ---------------------------------------------------------------------------
// eth_wb_pkg
// Shared definitions for the Ethernet Wishbone frame paths.
//   rx_state_t      : read-side frame state machine encoding
//   ADDR_DATA/STAT  : Wishbone register map (one address bit)
//   STAT_*          : bit positions inside the STATUS word
//   CTRL_*          : bit positions inside a CTRL write
// ---------------------------------------------------------------------------
package eth_wb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_WAIT  = 3'd1,
    READY     = 3'd2,
    DATA_WAIT = 3'd3,
    FLUSH     = 3'd4
  } rx_state_t;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int STAT_READY     = 31;
  localparam int STAT_UNDERFLOW = 30;

  localparam int CTRL_DROP   = 0;
  localparam int CTRL_CLR_UF = 1;

endpackage

// File: rtl/wb_rx_reader_if.sv
// ---------------------------------------------------------------------------
// wb_rx_reader_if
// Wishbone pipelined bus bundle for the RX frame reader.
//   i_wb_cyc/stb/we/addr/data : request from the bus master
//   o_wb_ack/stall/data       : response from the slave
// Handshake: a request is taken on a rising edge where cyc && stb && !stall;
// exactly one ack pulse follows every taken request, and no ack is ever
// produced without one.
// ---------------------------------------------------------------------------
interface wb_rx_reader_if #(
  parameter int DW = 32
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic          i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic          o_wb_ack;
  logic          o_wb_stall;
  logic [DW-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wb_rx_reader.sv
// ---------------------------------------------------------------------------
// wb_rx_reader
// Wishbone slave that hands received Ethernet frames from the RX word FIFO
// to the CPU, one word per DATA read. Each frame in the FIFO is led by a
// header word whose low CW bits hold the data word count; the header is
// consumed here and the count left is visible in STATUS.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : Wishbone slave (addr 0 = DATA, addr 1 = STATUS/CTRL)
//   i_fifo_empty  : RX FIFO empty flag
//   o_fifo_rd     : FIFO pop (combinational); word appears next cycle
//   i_fifo_data   : FIFO read data
//   dbg_state     : current frame state
//
// STATUS read : {frame_ready, underflow, 21'b0, remaining}
// CTRL write  : bit0 drops the rest of the current frame (READY only),
//               bit1 clears the sticky underflow flag.
// ---------------------------------------------------------------------------
module wb_rx_reader
  import eth_wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_rx_reader_if.slave  bus,
  input  logic           i_fifo_empty,
  output logic           o_fifo_rd,
  input  logic [DW-1:0]  i_fifo_data,
  output rx_state_t      dbg_state
);

  rx_state_t     state;
  logic [CW-1:0] remaining;
  logic          underflow;
  logic          ack_q;
  logic [DW-1:0] rdata_q;

  logic          req;
  logic          data_rd;
  logic          stat_rd;
  logic          ctrl_wr;
  logic          stall;
  logic          accept;
  logic          pop;
  logic          resp_now;
  logic [DW-1:0] status;

  // Only the two CTRL bits of the write data carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus.i_wb_data[DW-1:2];

  assign req     = bus.i_wb_cyc && bus.i_wb_stb;
  assign data_rd = req && !bus.i_wb_we && (bus.i_wb_addr == ADDR_DATA);
  assign stat_rd = req && !bus.i_wb_we && (bus.i_wb_addr == ADDR_STAT);
  assign ctrl_wr = req &&  bus.i_wb_we && (bus.i_wb_addr == ADDR_STAT);

  // Stall: the busy states never take requests; in READY only a DATA read
  // that would find the FIFO empty (mid-frame starvation) is held off.
  always_comb begin
    stall = 1'b0;
    case (state)
      HDR_WAIT, DATA_WAIT, FLUSH: stall = 1'b1;
      READY:                      stall = data_rd && i_fifo_empty;
      default:                    stall = 1'b0;
    endcase
  end

  assign accept = req && !stall;

  // FIFO pop: header fetch in IDLE, one word per accepted read in READY,
  // and free-running discard in FLUSH until the frame is gone.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !i_fifo_empty;
      READY:   pop = accept && data_rd;
      FLUSH:   pop = !i_fifo_empty && (remaining != '0);
      default: pop = 1'b0;
    endcase
  end

  // Gated so no pop leaks out while reset is held.
  assign o_fifo_rd = rst_n && pop;

  always_comb begin
    status                 = '0;
    status[STAT_READY]     = (state == READY);
    status[STAT_UNDERFLOW] = underflow;
    status[CW-1:0]         = remaining;
  end

  // Every accepted request answers on the next edge except a READY data
  // read, whose answer comes out of DATA_WAIT once the FIFO word arrives.
  assign resp_now = accept && !((state == READY) && data_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      underflow <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;

      if (resp_now) begin
        ack_q   <= 1'b1;
        rdata_q <= stat_rd ? status : '0;
        if (ctrl_wr && bus.i_wb_data[CTRL_CLR_UF]) begin
          underflow <= 1'b0;
        end
        // A DATA read with no frame loaded is a CPU-side underflow.
        if (data_rd && (state == IDLE)) begin
          underflow <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!i_fifo_empty) begin
            state <= HDR_WAIT;
          end
        end

        HDR_WAIT: begin
          remaining <= i_fifo_data[CW-1:0];
          // A zero-length frame leaves nothing to read; skip straight back.
          if (i_fifo_data[CW-1:0] == '0) begin
            state <= IDLE;
          end else begin
            state <= READY;
          end
        end

        READY: begin
          if (accept && data_rd) begin
            state <= DATA_WAIT;
          end else if (accept && ctrl_wr && bus.i_wb_data[CTRL_DROP]) begin
            state <= FLUSH;
          end
        end

        DATA_WAIT: begin
          // The popped word is delivered even if the master dropped cyc.
          rdata_q <= i_fifo_data;
          ack_q   <= 1'b1;
          if (remaining != '0) begin
            remaining <= remaining - CW'(1);
          end
          if (remaining <= CW'(1)) begin
            state <= IDLE;
          end else begin
            state <= READY;
          end
        end

        FLUSH: begin
          if (remaining == '0) begin
            state <= IDLE;
          end else if (!i_fifo_empty) begin
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_wb_ack   = ack_q;
  assign bus.o_wb_data  = rdata_q;
  assign bus.o_wb_stall = stall;
  assign dbg_state      = state;

endmodule

// File: tb/tb_wb_rx_reader.sv
module tb_wb_rx_reader;
  import eth_wb_pkg::*;

  localparam int DW        = 32;
  localparam int CW        = 9;
  localparam int STALL_MAX = 1000;
  localparam int ACK_MAX   = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_rx_reader_if #(.DW(DW)) bus ();

  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data  = '0;
  rx_state_t     dbg_state;

  wb_rx_reader #(.DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd    (fifo_rd),
    .i_fifo_data  (fifo_data),
    .dbg_state    (dbg_state)
  );

  // ---------------- FIFO model ----------------
  // Words are staged in pend_q (written mid-high-phase) and enter the FIFO
  // on the falling edge; pops happen on the rising edge with the word
  // appearing on fifo_data after that edge.
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] fifo_q[$];
  int            pop_count = 0;

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (fifo_rd && fifo_q.size() > 0) begin
        fifo_data <= fifo_q.pop_front();
        pop_count++;
      end
    end else begin
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic push_frame(input int hdr, input int nwords);
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    pend_q.push_back(DW'(hdr));
    for (int i = 0; i < nwords; i++) begin
      w = $urandom;
      pend_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic addr, input logic [DW-1:0] wdata,
                         output logic [DW-1:0] rdata, output int lat, output int stalls);
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = wdata;
    stalls = 0;
    #1;
    while (bus.o_wb_stall && stalls < STALL_MAX) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= STALL_MAX) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got stall still high expected release within %0d", STALL_MAX);
    end
    @(posedge clk);
    #1;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 1'b0;
    bus.i_wb_data = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_wb_ack && lat < ACK_MAX);
    rdata = bus.o_wb_data;
    bus.i_wb_cyc = 1'b0;
    @(negedge clk);
    check("ack_single", 32'(bus.o_wb_ack), 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic addr, input logic [31:0] exp, input int exp_lat);
    logic [DW-1:0] d;
    int lat, st;
    wb_xfer(1'b0, addr, '0, d, lat, st);
    check({name, "_data"}, d, exp);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic wr_chk(input string name, input logic addr, input logic [31:0] wdata);
    logic [DW-1:0] d;
    int lat, st;
    wb_xfer(1'b1, addr, wdata, d, lat, st);
    check({name, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wait_state(input rx_state_t target);
    int n;
    n = 0;
    while (dbg_state != target && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", 32'(dbg_state), 32'(target));
  endtask

  // CTRL drop of n remaining words: one pop per cycle, then IDLE, then quiet.
  task automatic drop_check(input int n);
    int base;
    base = pop_count;
    wr_chk("drop", ADDR_STAT, 32'h1);
    check("drop_pop1", 32'(pop_count - base), 32'd1);
    for (int k = 2; k <= n; k++) begin
      check("drop_flush_state", 32'(dbg_state), 32'(FLUSH));
      @(negedge clk);
      check("drop_pops", 32'(pop_count - base), 32'(k));
    end
    check("drop_idle", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("drop_pops_end", 32'(pop_count - base), 32'(n));
    for (int k = 0; k < n; k++) void'(exp_q.pop_front());
  endtask

  // ---------------- table vectors (IDLE, empty FIFO) ----------------
  typedef struct {
    logic        we;
    logic        addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  vec_t vecs[11];

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    int lat, st, len, k, rem;

    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 1'b0;
    bus.i_wb_data = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",   32'(bus.o_wb_ack),   32'd0);
    check("rst_data",  bus.o_wb_data,       32'd0);
    check("rst_stall", 32'(bus.o_wb_stall), 32'd0);
    check("rst_rd",    32'(fifo_rd),        32'd0);
    check("rst_state", 32'(dbg_state),      32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0]  = '{1'b0, ADDR_STAT, 32'h0, 1'b1, 32'h0000_0000, "stat_reset"};
    vecs[1]  = '{1'b0, ADDR_DATA, 32'h0, 1'b1, 32'h0000_0000, "uf_read"};
    vecs[2]  = '{1'b0, ADDR_STAT, 32'h0, 1'b1, 32'h4000_0000, "stat_uf"};
    vecs[3]  = '{1'b1, ADDR_DATA, 32'hDEAD_BEEF, 1'b0, 32'h0, "data_wr"};
    vecs[4]  = '{1'b1, ADDR_STAT, 32'h1, 1'b0, 32'h0, "drop_in_idle"};
    vecs[5]  = '{1'b0, ADDR_STAT, 32'h0, 1'b1, 32'h4000_0000, "stat_uf_kept"};
    vecs[6]  = '{1'b1, ADDR_STAT, 32'h2, 1'b0, 32'h0, "clr_uf"};
    vecs[7]  = '{1'b0, ADDR_STAT, 32'h0, 1'b1, 32'h0000_0000, "stat_cleared"};
    vecs[8]  = '{1'b0, ADDR_DATA, 32'h0, 1'b1, 32'h0000_0000, "uf_read2"};
    vecs[9]  = '{1'b1, ADDR_STAT, 32'h3, 1'b0, 32'h0, "clr_uf_drop"};
    vecs[10] = '{1'b0, ADDR_STAT, 32'h0, 1'b1, 32'h0000_0000, "stat_cleared2"};

    for (int i = 0; i < 11; i++) begin
      wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, d, lat, st);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
      if (vecs[i].chk_data) check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
    end

    // Header 3 then A, B, C: header takes two cycles, reads take two each.
    push_frame(3, 3);
    @(negedge clk);
    @(negedge clk);
    check("hdr_wait_state", 32'(dbg_state), 32'(HDR_WAIT));
    @(negedge clk);
    check("hdr_ready_state", 32'(dbg_state), 32'(READY));
    for (int i = 0; i < 3; i++) rd_chk("frame3_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("frame3_stat_end", ADDR_STAT, 32'h0000_0000, 1);

    // STATUS mid-frame, then drop four words.
    push_frame(5, 5);
    wait_state(READY);
    rd_chk("frame5_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("frame5_stat", ADDR_STAT, 32'h8000_0004, 1);
    drop_check(4);

    // Drop of header 4 after one read, next header still fetched right.
    push_frame(4, 4);
    wait_state(READY);
    rd_chk("frame4_rd", ADDR_DATA, exp_q.pop_front(), 2);
    drop_check(3);
    push_frame(2, 2);
    wait_state(READY);
    rd_chk("after_drop_stat", ADDR_STAT, 32'h8000_0002, 1);
    rd_chk("after_drop_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("after_drop_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("after_drop_stat_end", ADDR_STAT, 32'h0, 1);

    // Starvation: second word arrives late, read is held by stall.
    push_frame(2, 1);
    wait_state(READY);
    rd_chk("starve_rd1", ADDR_DATA, exp_q.pop_front(), 2);
    w = $urandom;
    fork
      wb_xfer(1'b0, ADDR_DATA, '0, d, lat, st);
      begin
        repeat (6) @(posedge clk);
        #1;
        pend_q.push_back(w);
      end
    join
    check("starve_data", d, w);
    check("starve_lat", 32'(lat), 32'd2);
    check("starve_stalled", 32'(st >= 4), 32'd1);
    rd_chk("starve_stat_end", ADDR_STAT, 32'h0, 1);

    // Zero-length frame, then one followed immediately by a real frame.
    push_frame(0, 0);
    repeat (3) @(negedge clk);
    check("zero_idle", 32'(dbg_state), 32'(IDLE));
    wb_xfer(1'b0, ADDR_STAT, '0, d, lat, st);
    check("zero_stat", d, 32'h0);
    check("zero_no_stall", 32'(st), 32'd0);
    push_frame(0, 0);
    push_frame(2, 2);
    wait_state(READY);
    rd_chk("post_zero_stat", ADDR_STAT, 32'h8000_0002, 1);
    rd_chk("post_zero_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("post_zero_rd", ADDR_DATA, exp_q.pop_front(), 2);

    // Maximum header 511.
    push_frame(511, 511);
    wait_state(READY);
    rd_chk("max_stat", ADDR_STAT, 32'h8000_01FF, 1);
    rd_chk("max_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("max_rd", ADDR_DATA, exp_q.pop_front(), 2);
    rd_chk("max_stat2", ADDR_STAT, 32'h8000_01FD, 1);
    drop_check(509);
    rd_chk("max_stat_end", ADDR_STAT, 32'h0, 1);

    // cyc dropped during DATA_WAIT, then reset during DATA_WAIT.
    push_frame(3, 3);
    wait_state(READY);
    @(negedge clk);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = ADDR_DATA;
    @(posedge clk);
    #1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    check("cycdrop_state", 32'(dbg_state), 32'(DATA_WAIT));
    @(negedge clk);
    check("cycdrop_no_ack_yet", 32'(bus.o_wb_ack), 32'd0);
    @(negedge clk);
    check("cycdrop_ack", 32'(bus.o_wb_ack), 32'd1);
    check("cycdrop_data", bus.o_wb_data, exp_q.pop_front());

    @(negedge clk);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = ADDR_DATA;
    @(posedge clk);
    #1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    check("rstmid_state_pre", 32'(dbg_state), 32'(DATA_WAIT));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_ack",   32'(bus.o_wb_ack), 32'd0);
    check("rstmid_data",  bus.o_wb_data,     32'd0);
    check("rstmid_state", 32'(dbg_state),    32'(IDLE));
    check("rstmid_no_pop", 32'(fifo_rd),     32'd0);
    fifo_q.delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rstmid_stat", ADDR_STAT, 32'h0, 1);

    // Randomized frames against the count/queue model.
    for (int f = 0; f < 15; f++) begin
      len = $urandom_range(0, 7);
      push_frame(len, len);
      if (len == 0) begin
        repeat (3) @(negedge clk);
        check("rnd_zero_idle", 32'(dbg_state), 32'(IDLE));
      end else begin
        wait_state(READY);
        rd_chk("rnd_stat_start", ADDR_STAT, 32'h8000_0000 | 32'(len), 1);
        k = $urandom_range(1, len);
        for (int i = 0; i < k; i++) begin
          rd_chk("rnd_rd", ADDR_DATA, exp_q.pop_front(), 2);
          rem = len - i - 1;
          if ($urandom_range(0, 1) == 1)
            rd_chk("rnd_stat", ADDR_STAT, (rem > 0) ? (32'h8000_0000 | 32'(rem)) : 32'h0, 1);
        end
        if (k < len) drop_check(len - k);
        rd_chk("rnd_stat_end", ADDR_STAT, 32'h0, 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        rd_chk("rnd_uf_rd", ADDR_DATA, 32'h0, 1);
        rd_chk("rnd_uf_stat", ADDR_STAT, 32'h4000_0000, 1);
        wr_chk("rnd_uf_clr", ADDR_STAT, 32'h2);
        rd_chk("rnd_uf_stat_clr", ADDR_STAT, 32'h0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
